// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates BRANCH/JAL/JALR, registers a one-cycle
// redirect toward fetch, trains a 2-bit BHT and counts mispredictions.
module branch_resolve_unit #(
  parameter int XLEN        = 64,
  parameter int IMM_W       = 21,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush_in,
  input  logic [XLEN-1:0]   pc,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [IMM_W-1:0]  imm,
  input  logic [XLEN-1:0]   data_rs1,
  input  logic [XLEN-1:0]   data_rs2,
  input  logic              pred_taken,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              lookup_taken,
  output logic              out_valid,
  output logic              taken,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   link_data,
  output logic              illegal,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0] bht [BHT_ENTRIES];

  logic             is_branch, is_jal, is_jalr, accept;
  logic             br_illegal, legal_branch, cond_taken;
  logic [XLEN-1:0]  simm, pc_plus4, br_target, jalr_sum, target;
  logic             nxt_taken, nxt_redirect;
  logic [XLEN-1:0]  nxt_redirect_pc, nxt_link;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             unused_lookup_bits;

  assign simm      = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign pc_plus4  = pc + XLEN'(4);
  assign br_target = pc + simm;
  assign jalr_sum  = data_rs1 + simm;

  assign is_branch    = (opcode == OP_BRANCH);
  assign is_jal       = (opcode == OP_JAL);
  assign is_jalr      = (opcode == OP_JALR);
  assign accept       = in_valid & ~flush_in & (is_branch | is_jal | is_jalr);
  assign br_illegal   = is_branch & (func3[2:1] == 2'b01);
  assign legal_branch = is_branch & ~br_illegal;

  always_comb begin
    cond_taken = 1'b0;
    case (func3)
      3'b000:  cond_taken = (data_rs1 == data_rs2);
      3'b001:  cond_taken = (data_rs1 != data_rs2);
      3'b100:  cond_taken = ($signed(data_rs1) <  $signed(data_rs2));
      3'b101:  cond_taken = ($signed(data_rs1) >= $signed(data_rs2));
      3'b110:  cond_taken = (data_rs1 <  data_rs2);
      3'b111:  cond_taken = (data_rs1 >= data_rs2);
      default: cond_taken = 1'b0;
    endcase
  end

  // JALR always redirects: fetch has no way to predict a register target.
  always_comb begin
    target          = is_jalr ? (jalr_sum & ~XLEN'(1)) : br_target;
    nxt_taken       = is_jal | is_jalr | (legal_branch & cond_taken);
    nxt_redirect    = is_jalr | (is_jal & ~pred_taken) |
                      (legal_branch & (cond_taken != pred_taken));
    nxt_redirect_pc = '0;
    if (nxt_redirect)
      nxt_redirect_pc = nxt_taken ? target : pc_plus4;
    nxt_link        = (is_jal | is_jalr) ? pc_plus4 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      link_data   <= '0;
      illegal     <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      taken       <= nxt_taken;
      redirect    <= nxt_redirect;
      redirect_pc <= nxt_redirect_pc;
      link_data   <= nxt_link;
      illegal     <= br_illegal;
    end else begin
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      link_data   <= '0;
      illegal     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      mispredict_cnt <= '0;
    else if (accept && nxt_redirect && (mispredict_cnt != {CNT_W{1'b1}}))
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
  end

  assign wr_idx = pc[IDX_W+1:2];
  assign rd_idx = lookup_pc[IDX_W+1:2];

  // Entries come out of reset weakly not-taken; counters saturate at both ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (accept && legal_branch) begin
      if (cond_taken) begin
        if (bht[wr_idx] != 2'b11)
          bht[wr_idx] <= bht[wr_idx] + 2'b01;
      end else begin
        if (bht[wr_idx] != 2'b00)
          bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
    end
  end

  assign lookup_taken       = bht[rd_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes reference-model
// expectations per cycle, monitor pops and compares after each rising edge.
module tb_branch_resolve_unit;

  localparam int CNT_W = 4;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ADD  = 7'b0110011;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0, flush_in = 1'b0, pred_taken = 1'b0;
  logic [63:0]       pc = '0, data_rs1 = '0, data_rs2 = '0, lookup_pc = '0;
  logic [6:0]        opcode = '0;
  logic [2:0]        func3 = '0;
  logic [20:0]       imm = '0;
  logic              lookup_taken, out_valid, taken, redirect, illegal;
  logic [63:0]       redirect_pc, link_data;
  logic [CNT_W-1:0]  mispredict_cnt;

  typedef struct {
    logic        valid, taken, redirect, illegal, lookup;
    logic [63:0] rpc, link;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   bht_m[64];
  int   cnt_m = 0;
  int   tests = 0;
  int   fails = 0;

  branch_resolve_unit #(.XLEN(64), .IMM_W(21), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush_in(flush_in), .pc(pc),
    .opcode(opcode), .func3(func3), .imm(imm), .data_rs1(data_rs1),
    .data_rs2(data_rs2), .pred_taken(pred_taken), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .out_valid(out_valid), .taken(taken),
    .redirect(redirect), .redirect_pc(redirect_pc), .link_data(link_data),
    .illegal(illegal), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and pushes what the outputs must be after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic fl,
                               input logic [63:0] p, input logic [6:0] op,
                               input logic [2:0] f3, input logic [20:0] im,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic pt, input logic [63:0] lpc);
    longint      simm;
    logic [63:0] tgt;
    logic        t;
    int          idx;
    exp_t        e;
    @(negedge clk);
    rst = r; in_valid = v; flush_in = fl; pc = p; opcode = op; func3 = f3;
    imm = im; data_rs1 = a; data_rs2 = b; pred_taken = pt; lookup_pc = lpc;
    #1;
    if (!r) checkOutput("lookup_old", 64'(lookup_taken), 64'(bht_m[(lpc >> 2) % 64] >= 2));

    e = '{valid: 0, taken: 0, redirect: 0, illegal: 0, lookup: 0, rpc: 0, link: 0, cnt: 0};
    simm = longint'(im);
    if (im[20]) simm = simm - 64'sd2097152;
    if (r) begin
      foreach (bht_m[i]) bht_m[i] = 1;
      cnt_m = 0;
    end else if (v && !fl && (op == BR || op == JAL || op == JALR)) begin
      e.valid = 1;
      if (op == BR) begin
        if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1;
        else begin
          case (f3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = (longint'(a) < longint'(b));
            3'd5: t = !(longint'(a) < longint'(b));
            3'd6: t = (a < b);
            default: t = !(a < b);
          endcase
          e.taken = t;
          e.redirect = (t != pt);
          if (e.redirect) e.rpc = t ? p + 64'(simm) : p + 64'd4;
          idx = int'((p >> 2) % 64);
          bht_m[idx] = t ? ((bht_m[idx] < 3) ? bht_m[idx] + 1 : 3)
                         : ((bht_m[idx] > 0) ? bht_m[idx] - 1 : 0);
        end
      end else begin
        e.taken = 1;
        e.link = p + 64'd4;
        e.redirect = (op == JALR) ? 1'b1 : !pt;
        tgt = (op == JALR) ? ((a + 64'(simm)) / 2) * 2 : p + 64'(simm);
        if (e.redirect) e.rpc = tgt;
      end
      if (e.redirect && cnt_m < (2**CNT_W - 1)) cnt_m++;
    end
    e.cnt = CNT_W'(cnt_m);
    e.lookup = (bht_m[(lpc >> 2) % 64] >= 2);
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("out_valid", 64'(out_valid), 64'(e.valid));
        checkOutput("taken", 64'(taken), 64'(e.taken));
        checkOutput("redirect", 64'(redirect), 64'(e.redirect));
        checkOutput("redirect_pc", redirect_pc, e.rpc);
        checkOutput("link_data", link_data, e.link);
        checkOutput("illegal", 64'(illegal), 64'(e.illegal));
        checkOutput("mispredict_cnt", 64'(mispredict_cnt), 64'(e.cnt));
        checkOutput("lookup_new", 64'(lookup_taken), 64'(e.lookup));
      end
    end
  end

  initial begin : driver
    logic [63:0] pool [4];
    logic [63:0] p, a, b;
    logic [6:0]  op;
    int          sel;
    pool[0] = 64'h100; pool[1] = 64'h104; pool[2] = 64'h200; pool[3] = 64'hFFFF_FFFF_FFFF_FFF0;

    applyStimulus(1, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 64'h100);
    applyStimulus(1, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 64'h100);
    // Plan 1: mispredicted BEQ, then idle holding lookup on the same entry
    applyStimulus(0, 1, 0, 64'h100, BR, 3'd0, 21'h20, 5, 5, 0, 64'h100);
    applyStimulus(0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 64'h100);
    // Plan 2: BLT / BLTU with -1 vs 1
    applyStimulus(0, 1, 0, 64'h300, BR, 3'd4, 21'h10, '1, 1, 1, 64'h300);
    applyStimulus(0, 1, 0, 64'h300, BR, 3'd6, 21'h10, '1, 1, 1, 64'h300);
    // Plan 3: JALR alignment, JAL correctly predicted
    applyStimulus(0, 1, 0, 64'h40, JALR, 3'd0, 21'h1FFFFE, 64'h1003, 0, 0, 64'h40);
    applyStimulus(0, 1, 0, 64'h40, JAL, 3'd0, 21'h1FFFF8, 0, 0, 1, 64'h40);
    // Plan 4: saturate up then down on one entry
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 64'h500, BR, 3'd0, 21'h8, 1, 1, 1, 64'h500);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 64'h500, BR, 3'd0, 21'h8, 1, 2, 0, 64'h500);
    // Plan 5: illegal func3, non-control opcode, flushed mispredict
    applyStimulus(0, 1, 0, 64'h600, BR, 3'd2, 21'h8, 1, 1, 0, 64'h600);
    applyStimulus(0, 1, 0, 64'h600, BR, 3'd3, 21'h8, 1, 1, 1, 64'h600);
    applyStimulus(0, 1, 0, 64'h600, ADD, 3'd0, 21'h8, 1, 1, 0, 64'h600);
    applyStimulus(0, 1, 1, 64'h600, BR, 3'd1, 21'h8, 1, 2, 0, 64'h600);
    // Plan 6: address wrap, then reset right after an accepted mispredict
    applyStimulus(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, BR, 3'd0, 21'h20, 7, 7, 0, 64'h0);
    applyStimulus(0, 1, 0, 64'h700, BR, 3'd0, 21'h20, 7, 7, 0, 64'h700);
    applyStimulus(1, 1, 0, 64'h700, BR, 3'd0, 21'h20, 7, 7, 0, 64'h700);
    applyStimulus(0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 64'h700);
    // Counter saturation with back-to-back JALRs
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 64'h80, JALR, 0, 21'h4, 64'h1000, 0, 1, 64'h80);
    applyStimulus(1, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 6) ? BR : (sel == 6) ? JAL : (sel == 7) ? JALR : (sel == 8) ? ADD : 7'($urandom);
      p = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 3)] : {$urandom, $urandom};
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {$urandom, $urandom};
        2: b = 64'($urandom_range(0, 7));
        default: b = ~a;
      endcase
      if ($urandom_range(0, 2) == 0) a = 64'($urandom_range(0, 7)) - 64'd3;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) == 0, p, op, 3'($urandom), 21'($urandom),
                    a, b, 1'($urandom), ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 3)] : 64'($urandom));
    end

    applyStimulus(0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
